// File: rtl/stream_rr_lock_arbiter.sv
// Round-robin arbiter that merges N_INP valid/ready streams into one downstream stream.
// The grant is combinational and is locked to the offered requester while the output is stalled.
module stream_rr_lock_arbiter #(
  parameter int  N_INP   = 4,
  parameter type T       = logic,
  parameter int  STALL_W = 8,
  localparam int IDX_W   = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic [N_INP-1:0]   valid_i,
  output logic [N_INP-1:0]   ready_o,
  input  T                   data_i [N_INP],
  output logic               valid_o,
  input  logic               ready_i,
  output T                   data_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic [STALL_W-1:0] stall_cnt_o
);

  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_next;
  logic               lock_q, lock_next;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_next;
  logic [STALL_W-1:0] stall_q, stall_next;

  logic               gated;
  logic               search_hit;
  logic [IDX_W-1:0]   search_idx;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   grant_inc;
  logic               offer;
  logic               handshake;

  assign gated = rst_i || clr_i;

  // Walk offsets from the far end so the candidate closest to rr_ptr_q wins last.
  always_comb begin
    search_hit = 1'b0;
    search_idx = '0;
    for (int k = N_INP - 1; k >= 0; k--) begin
      if (valid_i[(int'(rr_ptr_q) + k) % N_INP]) begin
        search_hit = 1'b1;
        search_idx = IDX_W'((int'(rr_ptr_q) + k) % N_INP);
      end
    end
  end

  assign grant     = lock_q ? lock_idx_q : search_idx;
  assign grant_inc = (grant == IDX_W'(N_INP - 1)) ? '0 : IDX_W'(grant + 1'b1);
  assign offer     = !gated && (lock_q || search_hit) && valid_i[grant];
  assign handshake = offer && ready_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      stall_q    <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_next;
      lock_q     <= lock_next;
      lock_idx_q <= lock_idx_next;
      stall_q    <= stall_next;
    end
  end

  // Next-state logic
  always_comb begin
    rr_ptr_next   = rr_ptr_q;
    lock_next     = 1'b0;
    lock_idx_next = lock_idx_q;
    stall_next    = '0;
    if (clr_i) begin
      rr_ptr_next   = '0;
      lock_idx_next = '0;
    end else if (handshake) begin
      rr_ptr_next = grant_inc;
    end else if (offer) begin
      lock_next     = 1'b1;
      lock_idx_next = grant;
      stall_next    = (&stall_q) ? stall_q : STALL_W'(stall_q + 1'b1);
    end
  end

  // Output logic
  always_comb begin
    valid_o     = offer;
    data_o      = gated ? T'('0) : data_i[grant];
    idx_o       = offer ? grant : '0;
    stall_cnt_o = rst_i ? '0 : stall_q;
  end

  generate
    for (genvar gi = 0; gi < N_INP; gi++) begin : g_ready
      assign ready_o[gi] = handshake && (grant == IDX_W'(gi));
    end
  endgenerate

  // A locked requester must keep its valid asserted until it is accepted.
  lock_valid_held : assert property (@(posedge clk_i) disable iff (rst_i || clr_i)
    lock_q |-> valid_i[lock_idx_q]);

endmodule

// File: tb/tb_stream_rr_lock_arbiter.sv
// Directed bench for stream_rr_lock_arbiter: a per-cycle reference model plus
// hand-computed expectations for reset, rotation, skipping, locking, saturation and clear.
module tb_stream_rr_lock_arbiter;
  localparam int N  = 4;
  localparam int SW = 3;

  logic         clk = 1'b0;
  logic         rst_i, clr_i, ready_i, valid_o;
  logic [N-1:0] valid_i, ready_o;
  logic [7:0]   data_i [N];
  logic [7:0]   data_o;
  logic [1:0]   idx_o;
  logic [SW-1:0] stall_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  stream_rr_lock_arbiter #(.N_INP(N), .T(logic [7:0]), .STALL_W(SW)) dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .idx_o(idx_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pointer, lock and stall counter kept as plain integers.
  int   m_ptr = 0, m_lock = 0, m_lidx = 0, m_stall = 0;
  int   g;
  logic e_valid;
  logic [N-1:0] e_ready;
  int   e_idx, e_stall;

  always @(negedge clk) begin
    g = -1;
    if (rst_i) begin
      e_valid = 1'b0; e_idx = 0; e_stall = 0;
    end else if (clr_i) begin
      e_valid = 1'b0; e_idx = 0; e_stall = m_stall;
    end else begin
      e_stall = m_stall;
      if (m_lock != 0) g = m_lidx;
      else
        for (int k = 0; k < N; k++)
          if (g < 0 && valid_i[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      e_valid = (g >= 0) ? valid_i[g] : 1'b0;
      e_idx   = e_valid ? g : 0;
    end
    e_ready = (e_valid && ready_i) ? N'(1 << g) : '0;
    check("m_valid", 32'(valid_o), 32'(e_valid));
    check("m_ready", 32'(ready_o), 32'(e_ready));
    check("m_idx", 32'(idx_o), e_idx);
    check("m_stall", 32'(stall_cnt_o), e_stall);
    if (e_valid) check("m_data", 32'(data_o), 32'(data_i[g]));
    if (rst_i || clr_i) begin
      m_ptr = 0; m_lock = 0; m_lidx = 0; m_stall = 0;
    end else if (e_valid && ready_i) begin
      m_ptr = (g + 1) % N; m_lock = 0; m_stall = 0;
    end else if (e_valid) begin
      m_lock = 1; m_lidx = g; m_stall = (m_stall == (1 << SW) - 1) ? m_stall : m_stall + 1;
    end else begin
      m_lock = 0; m_stall = 0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; clr_i = 1'b0; valid_i = 4'b1111; ready_i = 1'b1;
    for (int i = 0; i < N; i++) data_i[i] = 8'(8'h10 + i);

    // Reset hold
    repeat (3) begin
      @(negedge clk);
      check("rst_valid", 32'(valid_o), 0);
      check("rst_ready", 32'(ready_o), 0);
      check("rst_stall", 32'(stall_cnt_o), 0);
    end
    next_cycle();
    rst_i = 1'b0;

    // Rotation with all requesters valid
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rot_idx", 32'(idx_o), i % 4);
      check("rot_ready", 32'(ready_o), 32'(1 << (i % 4)));
      check("rot_data", 32'(data_o), 32'(8'h10 + i % 4));
      next_cycle();
    end

    // Sparse skip: move pointer to 1, then 1001 grants 3 then 0
    valid_i = 4'b0001;
    @(negedge clk); check("skip_pre", 32'(idx_o), 0); next_cycle();
    valid_i = 4'b1001;
    @(negedge clk); check("skip_a", 32'(idx_o), 3); next_cycle();
    @(negedge clk); check("skip_b", 32'(idx_o), 0); next_cycle();
    valid_i = 4'b1111;
    @(negedge clk); check("skip_ptr", 32'(idx_o), 1); next_cycle();

    // Lock under stall on requester 2
    valid_i = 4'b0100; data_i[2] = 8'hA5; ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) valid_i = 4'b0101;
      @(negedge clk);
      check("lock_idx", 32'(idx_o), 2);
      check("lock_data", 32'(data_o), 32'hA5);
      check("lock_stall", 32'(stall_cnt_o), k);
      check("lock_ready", 32'(ready_o), 0);
      next_cycle();
    end
    ready_i = 1'b1;
    @(negedge clk);
    check("lock_hs_idx", 32'(idx_o), 2);
    check("lock_hs_stall", 32'(stall_cnt_o), 5);
    check("lock_hs_ready", 32'(ready_o), 32'b0100);
    next_cycle();
    valid_i = 4'b1001; data_i[3] = 8'h33;
    @(negedge clk);
    check("after_lock_idx", 32'(idx_o), 3);
    check("after_lock_stall", 32'(stall_cnt_o), 0);
    next_cycle();

    // Stall counter saturation
    valid_i = 4'b0010; ready_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("sat_stall", 32'(stall_cnt_o), (k > 7) ? 7 : k);
      check("sat_idx", 32'(idx_o), 1);
      next_cycle();
    end
    ready_i = 1'b1;
    @(negedge clk);
    check("sat_hs_stall", 32'(stall_cnt_o), 7);
    check("sat_hs_ready", 32'(ready_o), 32'b0010);
    next_cycle();
    valid_i = 4'b0000;
    @(negedge clk);
    check("sat_clr_stall", 32'(stall_cnt_o), 0);
    check("sat_idle_valid", 32'(valid_o), 0);
    next_cycle();

    // Clear mid-stall: lock on 1 with pointer at 2
    valid_i = 4'b0010; ready_i = 1'b0;
    @(negedge clk); check("clr_pre_idx", 32'(idx_o), 1); next_cycle();
    valid_i = 4'b0110;
    @(negedge clk);
    check("clr_locked_idx", 32'(idx_o), 1);
    check("clr_locked_stall", 32'(stall_cnt_o), 1);
    next_cycle();
    clr_i = 1'b1;
    @(negedge clk);
    check("clr_valid", 32'(valid_o), 0);
    check("clr_ready", 32'(ready_o), 0);
    check("clr_idx", 32'(idx_o), 0);
    next_cycle();
    clr_i = 1'b0; ready_i = 1'b1;
    @(negedge clk);
    check("post_clr_idx", 32'(idx_o), 1);
    check("post_clr_stall", 32'(stall_cnt_o), 0);
    check("post_clr_ready", 32'(ready_o), 32'b0010);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/stream_rr_lock_arbiter.md
Name: stream_rr_lock_arbiter

Overview:
- Round-robin arbiter that shares one downstream valid/ready stream (typically the input of a fall-through register) among N_INP upstream requesters.
- Grant is combinational (zero-latency fall-through). Once the output is offered and stalled, the grant is locked so valid_o/data_o stay stable until the handshake completes.
- Provides grant index and a saturating stall counter for performance monitoring.

Parameters:
- N_INP, 4, number of requesters; legal range 1..64.
- T, logic, payload type carried on data_i/data_o.
- STALL_W, 8, width of stall_cnt_o.
- IDX_W, derived: $clog2(N_INP), minimum 1.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- clr_i  in  1  synchronous clear, same effect as rst_i, lower priority than rst_i.
- valid_i  in  N_INP  per-requester valid.
- ready_o  out  N_INP  per-requester ready.
- data_i  in  N_INP x T  per-requester payload.
- valid_o  out  1  downstream valid.
- ready_i  in  1  downstream ready.
- data_o  out  T  payload of granted requester.
- idx_o  out  IDX_W  index of granted requester; valid only when valid_o=1, otherwise 0.
- stall_cnt_o  out  STALL_W  consecutive cycles with valid_o && !ready_i, saturating.

Behaviour:
- State: rr_ptr_q (IDX_W), lock_q (1), lock_idx_q (IDX_W), stall_q (STALL_W).
- Reset and clear: rr_ptr_q=0, lock_q=0, lock_idx_q=0, stall_q=0. Outputs while in reset: valid_o=0, ready_o=0, data_o=0, idx_o=0, stall_cnt_o=0.
- clr_i=1 (rst_i=0): forces valid_o=0, ready_o=0 and idx_o=0 combinationally in that cycle; no handshake can occur; state is cleared on the next edge.
- Arbitration when lock_q=0:
  - Grant the first i with valid_i[i]=1, searching rr_ptr_q, rr_ptr_q+1, …, wrapping N_INP-1 -> 0.
  - If no valid_i is set, valid_o=0.
- Arbitration when lock_q=1: grant lock_idx_q; no search.
- Outputs:
  - valid_o = valid_i[grant].
  - data_o = data_i[grant].
  - idx_o = grant.
  - ready_o[grant] = ready_i; all other ready_o bits are 0.
- Combinational paths: valid_i/data_i -> valid_o/data_o and ready_i -> ready_o. There is no path from ready_i to valid_o or to the grant.
- Handshake (valid_o && ready_i):
  - rr_ptr_q <= grant+1, wrapping to 0 when grant = N_INP-1.
  - lock_q <= 0.
  - Latency 0 cycles from input to output.
- Stall (valid_o && !ready_i): lock_q <= 1, lock_idx_q <= grant; rr_ptr_q unchanged.
- No valid_o: lock_q <= 0; rr_ptr_q unchanged.
- Upstream contract: a requester holds valid_i high and data_i stable until ready_o. Violation while locked is an assertion error in simulation. RTL then releases the lock (valid_o drops, lock_q <= 0 next edge).
- Stall counter:
  - stall_q <= 0 on handshake or when valid_o=0.
  - stall_q <= stall_q+1 on stall; holds at all-ones (no wrap).
  - stall_cnt_o = stall_q.
- N_INP=1: grant is always 0, rr_ptr_q stays 0, lock logic still active.
- Fairness: with all requesters continuously valid and ready_i=1, grants cycle 0,1,…,N_INP-1,0.
- Downstream guarantee: valid_o && !ready_i |=> valid_o && $stable(data_o) && $stable(idx_o), provided upstream obeys its contract. Verification checks this with a bound property module.

Test Plan:
- Reset hold: rst_i=1 for 3 cycles with valid_i=4'b1111, ready_i=1 -> valid_o=0, ready_o=0, stall_cnt_o=0 throughout.
- Rotation: after reset, valid_i=4'b1111, ready_i=1 for 8 cycles -> idx_o sequence 0,1,2,3,0,1,2,3; exactly one ready_o bit high each cycle.
- Sparse skip: rr_ptr at 1, valid_i=4'b1001 -> grant 3 (cycle A), then 0 (cycle B), and rr_ptr=1 afterwards.
- Lock under stall:
  - Requester 2 granted with data 0xA5 and ready_i=0 for 5 cycles; requester 0 raises valid mid-stall.
  - Expected: idx_o=2 and data_o=0xA5 held for all 5 cycles; stall_cnt_o counts 1..5 (value shown the cycle after each stall); on ready_i=1 handshake, next grant searches from 3.
- Saturation: STALL_W=3 with 10 stall cycles -> stall_cnt_o reaches 7 and holds at 7; returns to 0 the cycle after the handshake.
- Clear mid-stall: locked on requester 1 with ptr=2, assert clr_i for 1 cycle -> valid_o=0 and ready_o=0 that cycle; next cycle ptr=0, unlocked, grant = lowest valid index, stall_cnt_o=0.
